// File: rtl/configs_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : configs_loader_if
// Brief    : Host-side stream and latch-bank bus bundle for configs_loader.
// Revision : 1.0
// ============================================================================
interface configs_loader_if #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 16
);
    logic                 io_start;
    logic                 io_abort;
    logic                 io_in_valid;
    logic                 io_in_ready;
    logic [WORD_W-1:0]    io_in_bits;
    logic [WORD_W-1:0]    io_d_in;
    logic [NUM_WORDS-1:0] io_configs_en;
    logic                 io_busy;
    logic                 io_done;

    modport master (
        output io_start, io_abort, io_in_valid, io_in_bits,
        input  io_in_ready, io_d_in, io_configs_en, io_busy, io_done
    );

    modport slave (
        input  io_start, io_abort, io_in_valid, io_in_bits,
        output io_in_ready, io_d_in, io_configs_en, io_busy, io_done
    );
endinterface
`default_nettype wire

// File: rtl/configs_loader.sv
`default_nettype none
// ============================================================================
// Module   : configs_loader
// Brief    : Sequences config words into a latch bank with setup/enable/hold.
// Revision : 1.0
// ============================================================================
module configs_loader #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 16,
    parameter int SETUP_CYC = 1,
    parameter int EN_CYC    = 1,
    parameter int HOLD_CYC  = 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    configs_loader_if.slave    bus
);

    localparam int CNT_MAX = (SETUP_CYC > EN_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((EN_CYC > HOLD_CYC) ? EN_CYC : HOLD_CYC);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETUP  = 3'd2,
        S_ENABLE = 3'd3,
        S_HOLD   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     idx, idx_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [WORD_W-1:0]    d_reg, d_nxt;
    logic [NUM_WORDS-1:0] en_reg, en_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            idx    <= '0;
            cnt    <= '0;
            d_reg  <= '0;
            en_reg <= '0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            cnt    <= cnt_nxt;
            d_reg  <= d_nxt;
            en_reg <= en_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        d_nxt     = d_reg;
        en_nxt    = '0;

        case (state)
            S_IDLE: begin
                if (bus.io_start && !bus.io_abort) begin
                    state_nxt = S_LOAD;
                    idx_nxt   = '0;
                end
            end
            S_LOAD: begin
                if (bus.io_in_valid) begin
                    d_nxt     = bus.io_in_bits;
                    state_nxt = S_SETUP;
                    cnt_nxt   = CNT_W'(SETUP_CYC - 1);
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    state_nxt = S_ENABLE;
                    cnt_nxt   = CNT_W'(EN_CYC - 1);
                end else begin
                    cnt_nxt   = cnt - CNT_W'(1);
                end
            end
            S_ENABLE: begin
                if (cnt == '0) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    cnt_nxt   = cnt - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    if (idx == IDX_W'(NUM_WORDS - 1)) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_LOAD;
                        idx_nxt   = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                idx_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase

        // Abort overrides everything but leaves the data bus stable for the latch.
        if (bus.io_abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
            idx_nxt   = '0;
            cnt_nxt   = '0;
            d_nxt     = d_reg;
        end

        // Enables come straight from a register loaded with the next state's decode.
        if (state_nxt == S_ENABLE) begin
            en_nxt = NUM_WORDS'(1) << idx_nxt;
        end
    end

    assign bus.io_in_ready   = (state == S_LOAD);
    assign bus.io_busy       = (state != S_IDLE);
    assign bus.io_done       = (state == S_DONE);
    assign bus.io_d_in       = d_reg;
    assign bus.io_configs_en = en_reg;

endmodule
`default_nettype wire

// File: tb/tb_configs_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_configs_loader
// Brief    : Two loader configurations against a schedule-based reference.
// Revision : 1.0
// ============================================================================
module tb_configs_loader;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_FLY  = 2;
    localparam int M_DONE = 3;
    localparam int NW     = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    configs_loader_if #(.WORD_W(32), .NUM_WORDS(NW)) bus0 ();
    configs_loader_if #(.WORD_W(32), .NUM_WORDS(NW)) bus1 ();

    configs_loader #(.WORD_W(32), .NUM_WORDS(NW), .SETUP_CYC(1), .EN_CYC(1), .HOLD_CYC(1))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));
    configs_loader #(.WORD_W(32), .NUM_WORDS(NW), .SETUP_CYC(2), .EN_CYC(3), .HOLD_CYC(2))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));

    int n_checks = 0;
    int n_fail   = 0;

    int ps[2] = '{1, 2};
    int pe[2] = '{1, 3};
    int ph[2] = '{1, 2};

    int          m_mode[2];
    int          m_k[2];
    int          m_acc[2];
    logic [31:0] m_d[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_IDLE;
            m_k[i]    = 0;
            m_acc[i]  = 0;
            m_d[i]    = '0;
        end
    endtask

    task automatic check_dut(input int i, input logic [NW-1:0] en, input logic [31:0] d,
                             input logic busy, input logic ready, input logic done);
        logic [NW-1:0] exp_en;
        int o;
        exp_en = '0;
        o = cyc - m_acc[i];
        if (m_mode[i] == M_FLY && o > ps[i] && o <= ps[i] + pe[i])
            exp_en = NW'(1) << m_k[i];
        check($sformatf("dut%0d_en", i),    64'(en),    64'(exp_en));
        check($sformatf("dut%0d_d_in", i),  64'(d),     64'(m_d[i]));
        check($sformatf("dut%0d_busy", i),  64'(busy),  64'(m_mode[i] != M_IDLE));
        check($sformatf("dut%0d_ready", i), 64'(ready), 64'(m_mode[i] == M_LOAD));
        check($sformatf("dut%0d_done", i),  64'(done),  64'(m_mode[i] == M_DONE));
    endtask

    task automatic model_update(input int i, input logic st, input logic ab,
                                input logic va, input logic [31:0] bits);
        if (m_mode[i] == M_IDLE) begin
            if (st && !ab) begin
                m_mode[i] = M_LOAD;
                m_k[i]    = 0;
            end
        end else if (ab) begin
            m_mode[i] = M_IDLE;
        end else if (m_mode[i] == M_LOAD) begin
            if (va) begin
                m_mode[i] = M_FLY;
                m_acc[i]  = cyc;
                m_d[i]    = bits;
            end
        end else if (m_mode[i] == M_FLY) begin
            if (cyc - m_acc[i] == ps[i] + pe[i] + ph[i]) begin
                if (m_k[i] == NW - 1) m_mode[i] = M_DONE;
                else begin
                    m_mode[i] = M_LOAD;
                    m_k[i]    = m_k[i] + 1;
                end
            end
        end else begin
            m_mode[i] = M_IDLE;
        end
    endtask

    // Called at a negedge: check this cycle's outputs, drive inputs, advance one edge.
    task automatic step(input logic st, input logic ab, input logic va, input logic seqb);
        logic [31:0] bits[2];
        check_dut(0, bus0.io_configs_en, bus0.io_d_in, bus0.io_busy, bus0.io_in_ready, bus0.io_done);
        check_dut(1, bus1.io_configs_en, bus1.io_d_in, bus1.io_busy, bus1.io_in_ready, bus1.io_done);
        for (int i = 0; i < 2; i++)
            bits[i] = seqb ? (32'hA000_0000 + 32'(m_k[i])) : 32'($urandom);
        bus0.io_start = st; bus0.io_abort = ab; bus0.io_in_valid = va; bus0.io_in_bits = bits[0];
        bus1.io_start = st; bus1.io_abort = ab; bus1.io_in_valid = va; bus1.io_in_bits = bits[1];
        for (int i = 0; i < 2; i++) model_update(i, st, ab, va, bits[i]);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Directed load: start at rel 0, valid low in [gap_lo,gap_hi], abort at abort_at.
    task automatic run(input int ncyc, input int gap_lo, input int gap_hi,
                       input int abort_at, input int start_again, input logic chk_done);
        int d0, d1;
        d0 = -1;
        d1 = -1;
        for (int r = 0; r < ncyc; r++) begin
            if (bus0.io_done && d0 < 0) d0 = r;
            if (bus1.io_done && d1 < 0) d1 = r;
            step((r == 0) || (r == start_again), r == abort_at,
                 !(r >= gap_lo && r <= gap_hi), 1'b1);
        end
        if (chk_done) begin
            check("done_cycle_dut0", 64'(d0), 64'(65));
            check("done_cycle_dut1", 64'(d1), 64'(129));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en0"},   64'(bus0.io_configs_en), 64'(0));
        check({tag, "_d0"},    64'(bus0.io_d_in),       64'(0));
        check({tag, "_busy0"}, 64'(bus0.io_busy),       64'(0));
        check({tag, "_rdy0"},  64'(bus0.io_in_ready),   64'(0));
        check({tag, "_done0"}, 64'(bus0.io_done),       64'(0));
        check({tag, "_en1"},   64'(bus1.io_configs_en), 64'(0));
        check({tag, "_d1"},    64'(bus1.io_d_in),       64'(0));
        check({tag, "_busy1"}, 64'(bus1.io_busy),       64'(0));
    endtask

    initial begin
        reset = 1'b0;
        bus0.io_start = 1'b0; bus0.io_abort = 1'b0; bus0.io_in_valid = 1'b0; bus0.io_in_bits = '0;
        bus1.io_start = 1'b0; bus1.io_abort = 1'b0; bus1.io_in_valid = 1'b0; bus1.io_in_bits = '0;
        model_reset();
        #2;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        for (int r = 0; r < 3; r++) step(1'b0, 1'b0, 1'b1, 1'b1);

        // Full load with a stray start at cycle 20; slow config runs alongside.
        run(140, -1, -1, -1, 20, 1'b1);
        // Valid withheld for five cycles in front of word 3.
        run(75, 13, 17, -1, -1, 1'b0);
        // Abort during word 7's enable pulse.
        run(40, -1, -1, 31, -1, 1'b0);
        // Start together with abort while idle must stay idle.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset in the middle of word 7's setup phase.
        run(30, -1, -1, -1, -1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        run(140, -1, -1, -1, -1, 1'b1);

        for (int r = 0; r < 3000; r++)
            step(($urandom % 16) == 0, ($urandom % 80) == 0, ($urandom % 4) != 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
